// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings, load-op codes and the EX->MEM bus layout for the MEM stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LB  = 3'b001,
        LD_LBU = 3'b010,
        LD_LH  = 3'b011,
        LD_LHU = 3'b100
    } ld_op_e;

    typedef struct packed {
        logic [2:0]  ld_op;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks byte/halfword/word from a little-endian read word and extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_op,
    output logic [31:0] aligned_load
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unassigned op codes fall through to a full-word load.
    always_comb begin
        aligned_load = rdata;
        case (ld_op)
            LD_LB:   aligned_load = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  aligned_load = {24'd0, byte_sel};
            LD_LH:   aligned_load = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  aligned_load = {16'd0, half_sel};
            default: aligned_load = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX->MEM register, SRAM read-data hold across stalls, load alignment, WB/ID buses.
// Optional misaligned-load detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_excp,
    output logic [31:0]             mem_badvaddr
);

    ex_to_mem_t  r_q, r_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] hold_data_q, hold_data_d;

    logic [31:0] rdata_eff;
    logic [31:0] aligned_load;
    logic [31:0] rf_wdata;
    logic        rf_we_out;

    always_comb begin
        r_d         = r_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        if (stall[3] == STOP && stall[4] == NO_STOP) begin
            r_d         = '0;
            hold_vld_d  = 1'b0;
            hold_data_d = '0;
        end else if (stall[3] == NO_STOP) begin
            r_d         = ex_to_mem_t'(ex_to_mem_bus);
            hold_vld_d  = 1'b0;
            hold_data_d = '0;
        end else if (!hold_vld_q) begin
            // SRAM data is only valid in the first MEM cycle; keep it for the rest of the stall.
            hold_vld_d  = 1'b1;
            hold_data_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            r_q         <= r_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign rdata_eff = hold_vld_q ? hold_data_q : data_sram_rdata;

    mem_load_align u_align (
        .rdata        (rdata_eff),
        .off          (r_q.ex_result[1:0]),
        .ld_op        (r_q.ld_op),
        .aligned_load (aligned_load)
    );

    assign rf_wdata = r_q.sel_rf_res ? aligned_load : r_q.ex_result;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (r_q.ld_op)
            LD_LB, LD_LBU: misaligned = 1'b0;
            LD_LH, LD_LHU: misaligned = r_q.ex_result[0];
            default:       misaligned = (r_q.ex_result[1:0] != 2'b00);
        endcase
    end

    assign mem_excp     = r_q.sel_rf_res & misaligned;
    assign mem_badvaddr = mem_excp ? r_q.ex_result : 32'd0;
    assign rf_we_out    = r_q.rf_we & ~mem_excp;
`else
    assign mem_excp     = 1'b0;
    assign mem_badvaddr = 32'd0;
    assign rf_we_out    = r_q.rf_we;
`endif

    assign mem_to_wb_bus = {r_q.pc, rf_we_out, r_q.rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we_out, r_q.rf_waddr, rf_wdata};

    logic unused_bits;
    assign unused_bits = ^{r_q.ram_en, r_q.ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: alignment, stall hold, bubble, reset and misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;
    logic        mem_excp;
    logic [31:0] mem_badvaddr;

    typedef struct packed {
        logic [69:0] wb;
        logic        excp;
        logic [31:0] bad;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus),
        .mem_excp        (mem_excp),
        .mem_badvaddr    (mem_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic excp, input logic [31:0] bad);
        exp_t e;
        e.wb   = {pc, we, wa, wd};
        e.excp = excp;
        e.bad  = bad;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        assert (mem_to_wb_bus === e.wb) else begin
            n_miss++;
            $error("FAIL %s wb_bus: got %h expected %h", tag, mem_to_wb_bus, e.wb);
        end
        n_vec++;
        assert (mem_to_id_bus === e.wb[37:0]) else begin
            n_miss++;
            $error("FAIL %s id_bus: got %h expected %h", tag, mem_to_id_bus, e.wb[37:0]);
        end
        n_vec++;
        assert (mem_excp === e.excp) else begin
            n_miss++;
            $error("FAIL %s excp: got %b expected %b", tag, mem_excp, e.excp);
        end
        n_vec++;
        assert (mem_badvaddr === e.bad) else begin
            n_miss++;
            $error("FAIL %s badvaddr: got %h expected %h", tag, mem_badvaddr, e.bad);
        end
        $display("[%0t] %s: wb=%h excp=%b bad=%h", $time, tag, mem_to_wb_bus, mem_excp, mem_badvaddr);
    endtask

    // Issue one instruction from EX, present SRAM data in its first MEM cycle, then check.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic sel,
                         input logic we, input logic [4:0] wa, input logic [31:0] pc,
                         input logic [31:0] rd, input logic [31:0] exp_wd,
                         input logic exp_we, input logic exp_excp, input string tag);
        @(negedge clk);
        stall         = 6'b000000;
        ex_to_mem_bus = {op, pc, 1'b1, 4'b0000, sel, we, wa, addr};
        push_exp(pc, exp_we, wa, exp_wd, exp_excp, exp_excp ? addr : 32'd0);
        @(posedge clk);
        #1 data_sram_rdata = rd;
        #1 check(tag);
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 6'b000000;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #2 push_exp(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        check("reset");
        @(negedge clk) rst = 1'b0;

        issue(3'b001, 32'h0000_0100, 1'b1, 1'b1, 5'd1, 32'h0040_0000, 32'h80FF_7F01, 32'h0000_0001, 1'b1, 1'b0, "lb_off0");
        issue(3'b001, 32'h0000_0101, 1'b1, 1'b1, 5'd2, 32'h0040_0004, 32'h80FF_7F01, 32'h0000_007F, 1'b1, 1'b0, "lb_off1");
        issue(3'b001, 32'h0000_0102, 1'b1, 1'b1, 5'd3, 32'h0040_0008, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b1, 1'b0, "lb_off2");
        issue(3'b001, 32'h0000_0103, 1'b1, 1'b1, 5'd4, 32'h0040_000C, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b1, 1'b0, "lb_off3");
        issue(3'b010, 32'h0000_0103, 1'b1, 1'b1, 5'd5, 32'h0040_0010, 32'h80FF_7F01, 32'h0000_0080, 1'b1, 1'b0, "lbu_off3");
        issue(3'b011, 32'h0000_0202, 1'b1, 1'b1, 5'd6, 32'h0040_0014, 32'h8001_7FFE, 32'hFFFF_8001, 1'b1, 1'b0, "lh_off2");
        issue(3'b100, 32'h0000_0200, 1'b1, 1'b1, 5'd7, 32'h0040_0018, 32'h8001_7FFE, 32'h0000_7FFE, 1'b1, 1'b0, "lhu_off0");
        issue(3'b000, 32'h0000_0200, 1'b1, 1'b1, 5'd8, 32'h0040_001C, 32'h8001_7FFE, 32'h8001_7FFE, 1'b1, 1'b0, "lw");
        issue(3'b111, 32'h0000_0204, 1'b1, 1'b1, 5'd9, 32'h0040_0020, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 1'b0, "op111_as_lw");
        issue(3'b000, 32'h1234_5678, 1'b0, 1'b1, 5'd5, 32'h0040_0024, 32'hA5A5_A5A5, 32'h1234_5678, 1'b1, 1'b0, "alu");

        // Stall hold: SRAM data changes while MEM is frozen, the result must not.
        issue(3'b000, 32'h0000_0300, 1'b1, 1'b1, 5'd10, 32'h0040_0028, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, "hold_enter");
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 data_sram_rdata = 32'h0000_0000;
            #1 push_exp(32'h0040_0028, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0, 32'd0);
            check($sformatf("hold_stall%0d", i));
        end
        issue(3'b000, 32'h0000_0304, 1'b1, 1'b1, 5'd11, 32'h0040_002C, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b0, "hold_release");

        // Bubble inserted into MEM.
        @(negedge clk);
        stall         = 6'b001000;
        ex_to_mem_bus = {3'b000, 32'h0040_0030, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd12, 32'h0000_0308};
        @(posedge clk);
        #1 data_sram_rdata = 32'hFFFF_FFFF;
        #1 push_exp(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        check("bubble");

        // Reset asserted while MEM is stalled on a load.
        issue(3'b000, 32'h0000_0400, 1'b1, 1'b1, 5'd13, 32'h0040_0034, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1, 1'b0, "pre_reset");
        stall = 6'b011000;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #2 push_exp(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        check("reset_in_stall");
        @(negedge clk) rst = 1'b0;
        issue(3'b000, 32'h0000_0404, 1'b1, 1'b1, 5'd14, 32'h0040_0038, 32'h7654_3210, 32'h7654_3210, 1'b1, 1'b0, "post_reset");

        // Misaligned loads: flagged and suppressed only when the check is built in.
        issue(3'b000, 32'h1000_0002, 1'b1, 1'b1, 5'd15, 32'h0040_003C, 32'hCAFE_F00D, 32'hCAFE_F00D, !CHK, CHK, "lw_misaligned");
        issue(3'b011, 32'h1000_0001, 1'b1, 1'b1, 5'd16, 32'h0040_0040, 32'h8001_7FFE, 32'h0000_7FFE, !CHK, CHK, "lh_misaligned");
        issue(3'b001, 32'h1000_0003, 1'b1, 1'b1, 5'd17, 32'h0040_0044, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b1, 1'b0, "lb_unaligned_ok");
        issue(3'b000, 32'h1000_0002, 1'b0, 1'b1, 5'd18, 32'h0040_0048, 32'h1111_2222, 32'h1000_0002, 1'b1, 1'b0, "alu_unaligned_ok");

        n_vec++;
        assert (sb.size() == 0) else begin
            n_miss++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
